// File: rtl/iterative_div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU): XLEN/UNROLL+1 cycles from request to response, 1 cycle for /0 and overflow.
// One operation in flight; result held in DONE until rsp_ready_i, and flush_i abandons the operation.
module iterative_div_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            rem_sel_q;
    logic            qneg_q, rneg_q;
    logic [XLEN-1:0] rem_q, quo_q, dsr_q, result_q;

    logic            is_signed, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN-1:0] rem_d, quo_d, q_fin, r_fin;
    logic [XLEN:0]   trial;

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign rsp_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;

    always_comb begin
        is_signed = ~op_i[0];
        a_neg     = is_signed & dividend_i[XLEN-1];
        b_neg     = is_signed & divisor_i[XLEN-1];
        a_abs     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        b_abs     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
        div_zero  = (divisor_i == '0);
        overflow  = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
    end

    // Quotient bits enter from the dividend MSB as it shifts into the partial remainder.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        trial = '0;
        for (int i = 0; i < UNROLL; i++) begin
            trial = {rem_d, quo_d[XLEN-1]};
            quo_d = {quo_d[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dsr_q}) begin
                trial    = trial - {1'b0, dsr_q};
                quo_d[0] = 1'b1;
            end
            rem_d = trial[XLEN-1:0];
        end
        q_fin = qneg_q ? (~quo_d + 1'b1) : quo_d;
        r_fin = rneg_q ? (~rem_d + 1'b1) : rem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            result_q  <= '0;
        end else if (flush_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        rem_sel_q <= op_i[1];
                        qneg_q    <= a_neg ^ b_neg;
                        rneg_q    <= a_neg;
                        dsr_q     <= b_abs;
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        if (div_zero) begin
                            state_q  <= DONE;
                            cnt_q    <= '0;
                            result_q <= op_i[1] ? dividend_i : '1;
                        end else if (overflow) begin
                            state_q  <= DONE;
                            cnt_q    <= '0;
                            result_q <= op_i[1] ? '0 : dividend_i;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CW'(STEPS);
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q  <= DONE;
                        result_q <= rem_sel_q ? r_fin : q_fin;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state_q  <= IDLE;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    result_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_div_unit.sv
// Directed plus random checks of the divider at UNROLL=1 and UNROLL=4 against a reference model.
module tb_iterative_div_unit;
    typedef struct packed {
        logic [31:0] res;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic        r1, r4;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0, divisor = '0;
    logic        flush = 1'b0;
    logic        rsp_rdy = 1'b1;
    logic        o1, o4, b1, b4;
    logic [31:0] res1, res4;

    int checks = 0;
    int failures = 0;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    iterative_div_unit #(.XLEN(32), .UNROLL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(v1), .req_ready_o(r1), .op_i(op),
        .dividend_i(dividend), .divisor_i(divisor), .flush_i(flush), .rsp_valid_o(o1),
        .rsp_ready_i(rsp_rdy), .result_o(res1), .busy_o(b1));

    iterative_div_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(v4), .req_ready_o(r4), .op_i(op),
        .dividend_i(dividend), .divisor_i(divisor), .flush_i(flush), .rsp_valid_o(o4),
        .rsp_ready_i(rsp_rdy), .result_o(res4), .busy_o(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return mop[1] ? a : 32'hFFFF_FFFF;
        case (mop)
            2'b00:   return ovf ? a : 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic logic [7:0] model_lat(input logic [1:0] mop, input logic [31:0] a,
                                             input logic [31:0] b, input int steps);
        if (b == 0) return 8'd1;
        if (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 8'd1;
        return 8'(steps + 1);
    endfunction

    // Presents one request, returns #1 after the accepting edge.
    task automatic issue(input bit sel, input logic [1:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        exp_t e;
        op = mop; dividend = a; divisor = b;
        chk(sel ? "req_ready4" : "req_ready1", sel ? r4 : r1, 1'b1);
        if (sel) v4 = 1'b1; else v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; v4 = 1'b0;
        e.res = model(mop, a, b);
        e.lat = model_lat(mop, a, b, sel ? 8 : 32);
        if (push) begin
            if (sel) q4.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic wait_rsp(input bit sel, input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        while (!(sel ? o4 : o1) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_vld"}, sel ? o4 : o1, 1'b1);
        chk({tag, "_q"}, sel ? q4.size() : q1.size(), 32'(1));
        if ((sel ? q4.size() : q1.size()) != 0) begin
            e = sel ? q4.pop_front() : q1.pop_front();
            chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
            chk({tag, "_res"}, sel ? res4 : res1, e.res);
        end
        if (rsp_rdy) begin
            @(posedge clk); #1;
            chk({tag, "_idle"}, sel ? b4 : b1, 1'b0);
        end
    endtask

    initial begin
        bit seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        #3;
        chk("rst_vld", o1, 1'b0);
        chk("rst_busy", b1, 1'b0);
        chk("rst_res", res1, 32'h0);
        chk("rst_rdy", r1, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 2'b00, 32'hFFFF_FFF9, 32'h2, 1);
        chk("calc_res0", res1, 32'h0);
        wait_rsp(0, "div_m7_2");
        issue(0, 2'b10, 32'hFFFF_FFF9, 32'h2, 1);   wait_rsp(0, "rem_m7_2");
        issue(0, 2'b01, 32'd100, 32'h0, 1);         wait_rsp(0, "divu_z");
        issue(0, 2'b11, 32'd100, 32'h0, 1);         wait_rsp(0, "remu_z");
        issue(0, 2'b00, 32'h8000_0000, '1, 1);      wait_rsp(0, "div_ovf");
        issue(0, 2'b10, 32'h8000_0000, '1, 1);      wait_rsp(0, "rem_ovf");

        rsp_rdy = 1'b0;
        issue(0, 2'b01, 32'hFFFF_FFFF, 32'h10, 1);
        wait_rsp(0, "bp");
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_vld", o1, 1'b1);
            chk("bp_res", res1, 32'h0FFF_FFFF);
            chk("bp_rdy", r1, 1'b0);
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle", b1, 1'b0);
        chk("bp_rdy_after", r1, 1'b1);

        issue(0, 2'b01, 32'd1000, 32'd3, 0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; #1;
        chk("fl_rdy_low", r1, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; #1;
        chk("fl_vld", o1, 1'b0);
        chk("fl_busy", b1, 1'b0);
        chk("fl_rdy", r1, 1'b1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (o1) seen = 1'b1; end
        chk("fl_no_rsp", 32'(seen), 32'h0);
        issue(0, 2'b01, 32'd20, 32'd3, 1);          wait_rsp(0, "divu_20_3");
        issue(0, 2'b11, 32'd20, 32'd3, 1);          wait_rsp(0, "remu_20_3");

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 5) rb = 32'h0;
            if (i == 6) rb = 32'hFFFF_FFFD;
            issue(0, rop, ra, rb, 1);
            wait_rsp(0, "rand1");
        end

        issue(1, 2'b11, 32'd1000, 32'd7, 1);        wait_rsp(1, "u4_remu");
        issue(1, 2'b00, 32'hFFFF_FFF9, 32'h2, 1);   wait_rsp(1, "u4_div");
        issue(1, 2'b01, 32'hDEAD_BEEF, 32'h10, 1);  wait_rsp(1, "u4_divu");
        issue(1, 2'b10, 32'h8000_0000, '1, 1);      wait_rsp(1, "u4_ovf");

        issue(1, 2'b01, 32'd5000, 32'd9, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("u4_midcalc_busy", b4, 1'b1);
        rst_n = 1'b0; #1;
        chk("u4_rst_busy", b4, 1'b0);
        chk("u4_rst_vld", o4, 1'b0);
        chk("u4_rst_res", res4, 32'h0);
        chk("u4_rst_rdy", r4, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (o4) seen = 1'b1; end
        chk("u4_rst_no_rsp", 32'(seen), 32'h0);
        issue(1, 2'b01, 32'd20, 32'd3, 1);          wait_rsp(1, "u4_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
